// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, ALU select codes, SKIP conditions,
// sequencer states and the decoded-instruction record.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_BACK  = 4'h8;
  localparam logic [3:0] OP_SKIP  = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_CLEAR = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_MUL  = 4'd7;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_DEC, S_M0, S_M1, S_AL, S_WB, S_ST, S_EX, S_HALT
  } state_t;

  typedef struct packed {
    logic       needs_operand;
    logic       uses_alu;
    logic [3:0] alu_sel;
    logic       is_store;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decode: selects the execution path taken after DEC.
// Pure logic, no state.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_LOAD:  o_dec.needs_operand = 1'b1;
      OP_STORE: o_dec.is_store      = 1'b1;
      OP_ADD:   o_dec = '{needs_operand: 1'b1, uses_alu: 1'b1, alu_sel: ALU_ADD, default: 1'b0};
      OP_SUB:   o_dec = '{needs_operand: 1'b1, uses_alu: 1'b1, alu_sel: ALU_SUB, default: 1'b0};
      OP_AND:   o_dec = '{needs_operand: 1'b1, uses_alu: 1'b1, alu_sel: ALU_AND, default: 1'b0};
      OP_OR:    o_dec = '{needs_operand: 1'b1, uses_alu: 1'b1, alu_sel: ALU_OR,  default: 1'b0};
      OP_NOT:   o_dec = '{needs_operand: 1'b1, uses_alu: 1'b1, alu_sel: ALU_NOT, default: 1'b0};
      OP_MUL:   o_dec = '{needs_operand: 1'b1, uses_alu: 1'b1, alu_sel: ALU_MUL, default: 1'b0};
      OP_HALT:  o_dec.is_halt       = 1'b1;
      default:  o_dec = '0;
    endcase
  end

endmodule

// File: rtl/accum_cpu_core.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU; owns PC/IR/MBR/AC.
// Memory and ALU controls are Moore outputs of the state register so reset kills them at once.
module accum_cpu_core
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] ac_o
);

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ir, r_mbr, r_ac, r_alu_a, r_alu_b;
  logic [3:0]            r_alu_sel;
  logic                  r_halted;
  logic [3:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_operand;
  logic                  w_skip;
  dec_t                  w_dec;

  assign w_opcode  = r_ir[DATA_WIDTH-1 -: 4];
  assign w_operand = r_ir[ADDR_WIDTH-1:0];

  cpu_decode u_decode (
    .i_opcode (w_opcode),
    .o_dec    (w_dec)
  );

  always_comb begin
    w_skip = 1'b0;
    case (r_ir[ADDR_WIDTH-1 -: 2])
      SKIP_NEG:  w_skip = r_ac[DATA_WIDTH-1];
      SKIP_ZERO: w_skip = (r_ac == '0);
      SKIP_POS:  w_skip = !r_ac[DATA_WIDTH-1] && (r_ac != '0);
      default:   w_skip = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_F0;
      S_F0:   w_next = S_F1;
      S_F1:   w_next = S_DEC;
      S_DEC: begin
        if (w_dec.is_halt)            w_next = S_HALT;
        else if (w_dec.is_store)      w_next = S_ST;
        else if (w_dec.needs_operand) w_next = S_M0;
        else                          w_next = S_EX;
      end
      S_M0:   w_next = S_M1;
      S_M1:   w_next = w_dec.uses_alu ? S_AL : S_WB;
      S_AL:   w_next = S_WB;
      S_WB, S_ST, S_EX: w_next = S_F0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    case (r_state)
      S_F0: begin mem_addr = r_pc;      mem_cs = 1'b1; mem_oe = 1'b1; end
      S_M0: begin mem_addr = w_operand; mem_cs = 1'b1; mem_oe = 1'b1; end
      S_ST: begin mem_addr = w_operand; mem_wdata = r_ac; mem_cs = 1'b1; mem_we = 1'b1; end
      default: ;
    endcase
  end

  // The ALU result is parked in MBR during AL so WB is the same AC<=MBR move for LOAD and ALU ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_mbr     <= '0;
      r_ac      <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= ALU_NONE;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_alu_sel <= (w_next == S_AL) ? w_dec.alu_sel : ALU_NONE;
      case (r_state)
        S_F1: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 1'b1;
        end
        S_DEC: if (w_dec.is_halt) r_halted <= 1'b1;
        S_M1: begin
          r_mbr <= mem_rdata;
          if (w_dec.uses_alu) begin
            r_alu_a <= r_ac;
            r_alu_b <= mem_rdata;
          end
        end
        S_AL: r_mbr <= alu_out;
        S_WB: r_ac  <= r_mbr;
        S_EX: begin
          case (w_opcode)
            OP_BACK:  r_pc <= r_pc - 1'b1;
            OP_SKIP:  if (w_skip) r_pc <= r_pc + 1'b1;
            OP_JUMP:  r_pc <= w_operand;
            OP_CLEAR: r_ac <= '0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_sel = r_alu_sel;
  assign halted  = r_halted;
  assign pc_o    = r_pc;
  assign ac_o    = r_ac;

endmodule
